// File: rtl/down_count_event.sv
// Watches a down-counter stream for a threshold match; optional wrap counting via DOWN_COUNT_EVENT_WRAP_EN.
// Latency: match on cnt_i in cycle N gives evt_valid from edge N+1.
// Backpressure: evt_valid holds with stable data until evt_ready; further matches while pending set overrun.
module down_count_event #(
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        cnt_i,
    input  logic [3:0]        thresh,
    input  logic              arm,
    input  logic              abort,
    input  logic              auto_rearm,
    input  logic              evt_ready,
    output logic              evt_valid,
    output logic [3:0]        evt_cnt,
    output logic [WRAP_W-1:0] evt_wraps,
    output logic              overrun,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        PEND  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  thr_q, thr_d;
    logic [3:0]  evt_cnt_q, evt_cnt_d;
    logic        overrun_q, overrun_d;
    logic        match;

    assign match = (cnt_i == thr_q);

`ifdef DOWN_COUNT_EVENT_WRAP_EN
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic [WRAP_W-1:0] wrap_nxt;
    logic [WRAP_W-1:0] evt_wraps_q, evt_wraps_d;
    logic              wrap_hit;

    // wrap_nxt already includes a wrap seen this cycle, so a capture sees it too
    always_comb begin
        wrap_hit = (state_q != IDLE) && (cnt_q == 4'd0) && (cnt_i == 4'hF);
        wrap_nxt = wrap_q;
        if (wrap_hit && (wrap_q != {WRAP_W{1'b1}})) begin
            wrap_nxt = wrap_q + WRAP_W'(1);
        end
    end

    assign evt_wraps = evt_wraps_q;
`else
    logic cnt_unused;
    assign cnt_unused = ^cnt_q;
    assign evt_wraps  = '0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_i;
        thr_d     = thr_q;
        evt_cnt_d = evt_cnt_q;
        overrun_d = overrun_q;
`ifdef DOWN_COUNT_EVENT_WRAP_EN
        wrap_d      = wrap_nxt;
        evt_wraps_d = evt_wraps_q;
`endif
        case (state_q)
            IDLE: begin
                if (arm && !abort) begin
                    state_d   = ARMED;
                    thr_d     = thresh;
                    overrun_d = 1'b0;
`ifdef DOWN_COUNT_EVENT_WRAP_EN
                    wrap_d    = '0;
`endif
                end
            end
            ARMED: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (match) begin
                    state_d   = PEND;
                    evt_cnt_d = cnt_i;
`ifdef DOWN_COUNT_EVENT_WRAP_EN
                    evt_wraps_d = wrap_nxt;
`endif
                end
            end
            PEND: begin
                // abort outranks both handshake and a lost match
                if (abort) begin
                    state_d = IDLE;
                end else if (evt_ready) begin
                    state_d = auto_rearm ? ARMED : IDLE;
                end else if (match) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'hF;
            thr_q     <= 4'd0;
            evt_cnt_q <= 4'd0;
            overrun_q <= 1'b0;
`ifdef DOWN_COUNT_EVENT_WRAP_EN
            wrap_q      <= '0;
            evt_wraps_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            thr_q     <= thr_d;
            evt_cnt_q <= evt_cnt_d;
            overrun_q <= overrun_d;
`ifdef DOWN_COUNT_EVENT_WRAP_EN
            wrap_q      <= wrap_d;
            evt_wraps_q <= evt_wraps_d;
`endif
        end
    end

    assign evt_valid = (state_q == PEND);
    assign busy      = (state_q != IDLE);
    assign evt_cnt   = evt_cnt_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_down_count_event.sv
// Scoreboarded bench for down_count_event: a reference model predicts events, the DUT's handshakes retire them.
// Works with or without DOWN_COUNT_EVENT_WRAP_EN defined.
module tb_down_count_event;

    localparam int WRAP_W   = 8;
    localparam int WRAP_MAX = (1 << WRAP_W) - 1;
    localparam int S_IDLE = 0, S_ARMED = 1, S_PEND = 2;

`ifdef DOWN_COUNT_EVENT_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        cnt_i;
    logic [3:0]        thresh;
    logic              arm, abort, auto_rearm, evt_ready;
    logic              evt_valid;
    logic [3:0]        evt_cnt;
    logic [WRAP_W-1:0] evt_wraps;
    logic              overrun, busy;

    down_count_event #(.WRAP_W(WRAP_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt_i      (cnt_i),
        .thresh     (thresh),
        .arm        (arm),
        .abort      (abort),
        .auto_rearm (auto_rearm),
        .evt_ready  (evt_ready),
        .evt_valid  (evt_valid),
        .evt_cnt    (evt_cnt),
        .evt_wraps  (evt_wraps),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        int w;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_hs   = 0;
    bit   hold   = 1'b0;

    int m_state, m_cnt_q, m_thr, m_wrap, m_ovr;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_cnt_q = 15;
        m_thr   = 0;
        m_wrap  = 0;
        m_ovr   = 0;
        exp_q.delete();
    endtask

    task automatic model_update();
        int c, w;
        bit hit;
        exp_t e;
        c   = int'(cnt_i);
        hit = WRAP_EN && (m_state != S_IDLE) && (m_cnt_q == 0) && (c == 15);
        w   = (hit && m_wrap < WRAP_MAX) ? m_wrap + 1 : m_wrap;
        if (m_state == S_IDLE) begin
            if (arm && !abort) begin
                m_state = S_ARMED;
                m_thr   = int'(thresh);
                m_wrap  = 0;
                m_ovr   = 0;
            end
        end else if (m_state == S_ARMED) begin
            m_wrap = w;
            if (abort) m_state = S_IDLE;
            else if (c == m_thr) begin
                m_state = S_PEND;
                e.c = c;
                e.w = w;
                exp_q.push_back(e);
            end
        end else begin
            m_wrap = w;
            if (abort) begin
                m_state = S_IDLE;
                if (exp_q.size() > 0) void'(exp_q.pop_back());
            end else if (evt_ready) begin
                m_state = auto_rearm ? S_ARMED : S_IDLE;
            end else if (c == m_thr) begin
                m_ovr = 1;
            end
        end
        m_cnt_q = c;
    endtask

    // Called at the falling edge with this cycle's inputs applied.
    task automatic tick();
        exp_t e;
        chk("evt_valid", int'(evt_valid), int'(m_state == S_PEND));
        chk("busy", int'(busy), int'(m_state != S_IDLE));
        chk("overrun", int'(overrun), m_ovr);
        if (evt_valid && evt_ready && !abort) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_evt", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("evt_cnt", int'(evt_cnt), e.c);
                chk("evt_wraps", int'(evt_wraps), e.w);
                n_hs++;
            end
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
        if (!hold) cnt_i = cnt_i - 4'd1;
    endtask

    task automatic start(input logic [3:0] c, input logic [3:0] t, input logic rearm, input logic rdy);
        cnt_i      = c;
        thresh     = t;
        auto_rearm = rearm;
        evt_ready  = rdy;
        arm        = 1'b1;
        tick();
        arm        = 1'b0;
        thresh     = 4'hA;
    endtask

    initial begin
        rst_n = 1'b0; cnt_i = 4'd9; thresh = 4'd0; arm = 1'b0; abort = 1'b0;
        auto_rearm = 1'b0; evt_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_evt_valid", int'(evt_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_evt_cnt", int'(evt_cnt), 0);
        chk("rst_evt_wraps", int'(evt_wraps), 0);
        rst_n = 1'b1;

        // thresh 5 from 9 downward, stalled downstream until the count returns to 5
        start(4'd9, 4'd5, 1'b0, 1'b0);
        chk("busy_after_arm", int'(busy), 1);
        repeat (4) tick();
        chk("pend_after_5", int'(evt_valid), 1);
        repeat (20) tick();
        chk("stall_evt_cnt", int'(evt_cnt), 5);
        chk("stall_overrun", int'(overrun), 1);
        evt_ready = 1'b1;
        tick();
        chk("idle_after_hs", int'(busy), 0);

        // wrap between arm and match
        start(4'd2, 4'd3, 1'b0, 1'b0);
        repeat (16) tick();
        chk("wrap_pend", int'(evt_valid), 1);
        chk("wrap_evt_wraps", int'(evt_wraps), WRAP_EN ? 1 : 0);
        evt_ready = 1'b1;
        tick();

        // auto re-arm, free running, thresh 0
        n_hs = 0;
        start(4'd14, 4'd0, 1'b1, 1'b1);
        repeat (47) tick();
        chk("rearm_events", n_hs, 3);
        chk("rearm_armed", int'(busy), 1);
        auto_rearm = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;

        // abort on the match cycle
        start(4'd9, 4'd7, 1'b0, 1'b0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_match_valid", int'(evt_valid), 0);
        chk("abort_match_busy", int'(busy), 0);
        chk("abort_match_q", exp_q.size(), 0);

        // abort on the handshake cycle
        start(4'd9, 4'd7, 1'b0, 1'b0);
        repeat (2) tick();
        chk("pre_abort_pend", int'(evt_valid), 1);
        evt_ready = 1'b1; abort = 1'b1;
        tick();
        abort = 1'b0; evt_ready = 1'b0;
        chk("abort_hs_valid", int'(evt_valid), 0);
        chk("abort_hs_busy", int'(busy), 0);

        // held count equal to threshold re-matches each time armed
        hold = 1'b1;
        n_hs = 0;
        start(4'd4, 4'd4, 1'b1, 1'b1);
        repeat (6) tick();
        chk("held_events", n_hs, 3);
        abort = 1'b1; auto_rearm = 1'b0;
        tick();
        abort = 1'b0; hold = 1'b0;

        // asynchronous reset in the middle of a pending event with overrun set
        start(4'd9, 4'd8, 1'b0, 1'b0);
        repeat (17) tick();
        chk("pre_rst_overrun", int'(overrun), 1);
        evt_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(evt_valid), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_overrun", int'(overrun), 0);
        model_reset();
        #1 rst_n = 1'b1;
        repeat (3) tick();
        chk("final_q_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/down_count_event.md
DOWN_COUNT_EVENT -- requirements
Module: down_count_event

Interface
REQ-001 SHALL provide parameter: WRAP_W, 8, width of the wrap (underflow) counter reported with each event.
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: cnt_i  input  4  count value consumed from the upstream 4-bit down counter.
REQ-005 SHALL provide port: thresh  input  4  match value; sampled only on arm acceptance.
REQ-006 SHALL provide port: arm  input  1  level; starts a watch when in IDLE.
REQ-007 SHALL provide port: abort  input  1  level; cancels a watch or a pending event.
REQ-008 SHALL provide port: auto_rearm  input  1  1 = return to ARMED after event handshake, 0 = return to IDLE.
REQ-009 SHALL provide port: evt_ready  input  1  downstream accepts the event.
REQ-010 SHALL provide port: evt_valid  output  1  event pending.
REQ-011 SHALL provide port: evt_cnt  output  4  cnt_i value that caused the match.
REQ-012 SHALL provide port: evt_wraps  output  WRAP_W  wraps seen since arm, captured at match.
REQ-013 SHALL provide port: overrun  output  1  sticky; a match was lost while an event was pending.
REQ-014 SHALL provide port: busy  output  1  high when state is not IDLE.

Function
REQ-015 SHALL register cnt_i every cycle into cnt_q (previous value).
REQ-016 SHALL implement FSM states IDLE, ARMED, PEND; encoding free.
REQ-017 IDLE: arm=1 and abort=0 -> ARMED next edge; thr_q <= thresh; wrap counter <= 0; overrun <= 0.
REQ-018 ARMED: cnt_i==thr_q -> PEND next edge; evt_cnt <= cnt_i; evt_wraps <= wrap counter (including a wrap detected that same cycle).
REQ-019 Match latency SHALL be exactly 1 cycle: match on cycle N cnt_i -> evt_valid=1 from edge N+1.
REQ-020 PEND: evt_valid=1; evt_cnt/evt_wraps SHALL stay stable until handshake (evt_valid & evt_ready).
REQ-021 On handshake: auto_rearm=1 -> ARMED (thr_q kept, wrap counter kept); auto_rearm=0 -> IDLE.
REQ-022 In PEND, cnt_i==thr_q on a non-handshake cycle SHALL set overrun; pending data not overwritten.
REQ-023 abort=1 in ARMED or PEND SHALL go to IDLE next edge, dropping evt_valid; abort wins over match and handshake in the same cycle.
REQ-024 arm ignored outside IDLE; thresh changes ignored outside arm acceptance.
REQ-025 Held/stalled cnt_i equal to thr_q SHALL re-match each time the FSM is ARMED (level match, no edge qualification).
REQ-026 busy SHALL be combinational from state only.

Reset
REQ-027 rst_n=0 SHALL immediately force: state IDLE, evt_valid 0, evt_cnt 0, evt_wraps 0, overrun 0, busy 0, cnt_q 4'hF, thr_q 0, wrap counter 0.
REQ-028 Reset mid-PEND SHALL discard the pending event; no handshake completes on the reset-release edge.
REQ-029 First edge after rst_n release SHALL behave as normal IDLE operation.

Configuration
REQ-030 Macro DOWN_COUNT_EVENT_WRAP_EN defined: wrap detected when cnt_q==0 and cnt_i==15 while ARMED or PEND; wrap counter increments, saturates at 2^WRAP_W-1.
REQ-031 Macro undefined: no wrap detection or counter logic; evt_wraps tied to 0; all other behaviour identical.

Verification
REQ-032 Reset, arm=1 thresh=5, counter descends 9..0 -> busy at edge 1; evt_valid rises the edge after cnt_i=5; evt_cnt=5.
REQ-033 evt_ready held 0 for 20 cycles while counter wraps and returns to 5 -> evt_valid held, evt_cnt=5 stable, overrun=1.
REQ-034 WRAP_EN defined, thresh=3, counter runs 2,1,0,15,...,3 after arm -> evt_wraps=1; macro undefined -> evt_wraps=0.
REQ-035 auto_rearm=1, evt_ready=1, thresh=0, 48 cycles free-running -> three single-cycle-accepted events, state returns to ARMED each time.
REQ-036 abort=1 on the same cycle as match and as handshake -> IDLE next edge, evt_valid=0, no event issued.
REQ-037 rst_n pulsed low mid-PEND (asynchronously, between edges) -> evt_valid, busy, overrun 0 immediately, before next edge.
